shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 21 ++
 rtl/shift_arbiter_shifter.sv | 23 ++
 rtl/shift_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared CPU shift definitions: op encodings, data width and result-slot states.
// The ALU decoder imports the same op encodings.
package shift_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 5;
    localparam int SH_W   = 4;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 16-bit shifter. It takes an already-normalized 4-bit amount,
// so it has no saturation logic of its own.
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SH_W-1:0]   amt,
    input  shift_op_e         op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = data;
        unique case (op)
            OP_LSL: result = data << amt;
            OP_LSR: result = data >> amt;
            OP_ASR: result = $unsigned($signed(data) >>> amt);
            // An amount of 0 shifts the left term out completely, leaving data.
            OP_ROR: result = (data >> amt) | (data << (AMT_W'(DATA_W) - {1'b0, amt}));
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared shifter, with a
// single registered result slot.
//   state      | meaning
//   SLOT_EMPTY | no result held, rsp_valid low
//   SLOT_FULL  | result held on rsp_data/rsp_id, rsp_valid high
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int INIT_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id
);

    slot_e             slot_q, slot_d;
    logic              prio_q;
    logic              slot_free, grant0, grant1, xfer;
    logic [DATA_W-1:0] sel_data, sh_data, sh_result;
    logic [AMT_W-1:0]  sel_amt;
    logic [SH_W-1:0]   norm_amt;
    shift_op_e         sel_op;

    assign slot_free  = (slot_q == SLOT_EMPTY) || rsp_ready;
    assign grant0     = req0_valid && (!req1_valid || !prio_q);
    assign grant1     = req1_valid && (!req0_valid || prio_q);
    assign req0_ready = rst_n && slot_free && grant0;
    assign req1_ready = rst_n && slot_free && grant1;
    assign xfer       = req0_ready || req1_ready;
    assign rsp_valid  = (slot_q == SLOT_FULL);

    // Amounts of 16 or more saturate here: logical shifts see zero data, and
    // ASR by 15 already replicates the sign bit across the word.
    always_comb begin
        sel_data = grant1 ? req1_data : req0_data;
        sel_amt  = grant1 ? req1_amt  : req0_amt;
        sel_op   = shift_op_e'(grant1 ? req1_op : req0_op);
        sh_data  = sel_data;
        norm_amt = sel_amt[SH_W-1:0];
        case (sel_op)
            OP_LSL, OP_LSR: if (sel_amt[AMT_W-1]) sh_data = '0;
            OP_ASR:         if (sel_amt[AMT_W-1]) norm_amt = '1;
            default: ;
        endcase
    end

    shift_arbiter_shifter u_shifter (
        .data   (sh_data),
        .amt    (norm_amt),
        .op     (sel_op),
        .result (sh_result)
    );

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SLOT_EMPTY: if (xfer) slot_d = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !xfer) slot_d = SLOT_EMPTY;
            default:    slot_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) slot_q <= SLOT_EMPTY;
        else        slot_q <= slot_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            prio_q   <= 1'(INIT_PRIO);
        end else if (xfer) begin
            rsp_data <= sh_result;
            rsp_id   <= grant1;
            prio_q   <= ~grant1;
        end
    end

endmodule
